pong_game_ctrl: RTL

//   Frame-rate game sequencer for the pong display path. Watches the 640x480 raster counters, runs
//   the serve/play/score/game-over state machine and updates ball, paddle and score registers once
//   per frame, at the start of vertical blank. The pong renderer consumes these outputs as

---
 rtl/pong_pkg.sv | 17 +
 rtl/paddle_mover.sv | 48 ++++
 rtl/pong_game_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: game state encoding and reset/centre coordinates,
// used by both the game controller and the renderer.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int         PAD_W   = 8;
  localparam logic [9:0] BALL_X0 = 10'd316;
  localparam logic [9:0] BALL_Y0 = 10'd236;
  localparam logic [9:0] PAD_Y0  = 10'd216;

endpackage

// File: rtl/paddle_mover.sv
// One paddle's vertical position: steps up/down once per enabled frame and
// saturates at the top and bottom of the active area.
module paddle_mover
  import pong_pkg::*;
#(
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 48,
  parameter int PADDLE_SPEED = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] pad_y
);

  localparam logic signed [10:0] Y_MAX = 11'(V_RES - PADDLE_H);
  localparam logic signed [10:0] STEP  = 11'(PADDLE_SPEED);

  logic signed [10:0] y_next;

  function automatic logic [9:0] clamp_y(input logic signed [10:0] v);
    if (v < 11'sd0)
      return 10'd0;
    else if (v > Y_MAX)
      return Y_MAX[9:0];
    else
      return v[9:0];
  endfunction

  always_comb begin
    y_next = $signed({1'b0, pad_y});
    if (up && !dn)
      y_next = $signed({1'b0, pad_y}) - STEP;
    else if (dn && !up)
      y_next = $signed({1'b0, pad_y}) + STEP;
  end

  always_ff @(posedge clk) begin
    if (rst || load)
      pad_y <= PAD_Y0;
    else if (en)
      pad_y <= clamp_y(y_next);
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: derives a frame strobe from the raster counters and
// advances ball, paddles, scores and game state once per frame in vertical blank.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 48,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       btn_start,
  input  logic       btn_up_l,
  input  logic       btn_dn_l,
  input  logic       btn_up_r,
  input  logic       btn_dn_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       frame_tick
);

  localparam logic signed [10:0] BALL_STEP = 11'(BALL_SPEED);
  localparam logic signed [10:0] BALL_SZ   = 11'(BALL_SIZE);
  localparam logic signed [10:0] PAD_HT    = 11'(PADDLE_H);
  localparam logic signed [10:0] PAD_WS    = 11'(PAD_W);
  localparam logic signed [10:0] L_X       = 11'(PAD_L_X);
  localparam logic signed [10:0] L_FACE    = 11'(PAD_L_X + PAD_W);
  localparam logic signed [10:0] R_X       = 11'(PAD_R_X);
  localparam logic signed [10:0] R_STOP    = 11'(PAD_R_X - BALL_SIZE);
  localparam logic signed [10:0] X_MAX     = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX     = 11'(V_RES - BALL_SIZE);

  game_state_t        state, state_n;
  logic               btn_q, start_rise;
  logic               dx, dy, dx_n, dy_n;  // 1 = moving toward larger coordinate
  logic [9:0]         ball_x_n, ball_y_n;
  logic [3:0]         score_l_n, score_r_n;
  logic [5:0]         serve_cnt, serve_cnt_n;
  logic               pad_load, pad_en;
  logic signed [10:0] nx, ny, by_s, pl_s, pr_s;
  logic               hit_l, hit_r;

  function automatic logic signed [10:0] to_s(input logic [9:0] v);
    return $signed({1'b0, v});
  endfunction

  assign start_rise = btn_start && !btn_q;
  assign game_state = state;
  assign pad_en     = frame_tick && (state == ST_SERVE || state == ST_PLAY);

  assign by_s = to_s(ball_y);
  assign pl_s = to_s(pad_l_y);
  assign pr_s = to_s(pad_r_y);
  assign nx   = to_s(ball_x) + (dx ? BALL_STEP : -BALL_STEP);
  assign ny   = by_s + (dy ? BALL_STEP : -BALL_STEP);

  // Vertical overlap is judged on the pre-move ball and paddle positions.
  assign hit_l = !dx && (nx <= L_FACE) && (nx + BALL_SZ > L_X) &&
                 (by_s + BALL_SZ > pl_s) && (by_s < pl_s + PAD_HT);
  assign hit_r = dx && (nx + BALL_SZ >= R_X) && (nx < R_X + PAD_WS) &&
                 (by_s + BALL_SZ > pr_s) && (by_s < pr_s + PAD_HT);

  always_comb begin
    state_n     = state;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    dx_n        = dx;
    dy_n        = dy;
    score_l_n   = score_l;
    score_r_n   = score_r;
    serve_cnt_n = serve_cnt;
    pad_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_n     = ST_SERVE;
          score_l_n   = 4'd0;
          score_r_n   = 4'd0;
          serve_cnt_n = 6'd0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt == 6'(SERVE_FRAMES - 1)) begin
            state_n     = ST_PLAY;
            serve_cnt_n = 6'd0;
          end else begin
            serve_cnt_n = serve_cnt + 6'd1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (ny < 11'sd0) begin
            ball_y_n = 10'd0;
            dy_n     = 1'b1;
          end else if (ny > Y_MAX) begin
            ball_y_n = Y_MAX[9:0];
            dy_n     = 1'b0;
          end else begin
            ball_y_n = ny[9:0];
          end
          if (hit_l) begin
            ball_x_n = L_FACE[9:0];
            dx_n     = 1'b1;
          end else if (hit_r) begin
            ball_x_n = R_STOP[9:0];
            dx_n     = 1'b0;
          end else if (nx < 11'sd0) begin
            score_r_n = score_r + 4'd1;
            ball_x_n  = BALL_X0;
            ball_y_n  = BALL_Y0;
            dx_n      = 1'b0;
            state_n   = (score_r_n == 4'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
          end else if (nx > X_MAX) begin
            score_l_n = score_l + 4'd1;
            ball_x_n  = BALL_X0;
            ball_y_n  = BALL_Y0;
            dx_n      = 1'b1;
            state_n   = (score_l_n == 4'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
          end else begin
            ball_x_n = nx[9:0];
          end
        end
      end
      ST_OVER: begin
        if (btn_start) begin
          state_n  = ST_IDLE;
          ball_x_n = BALL_X0;
          ball_y_n = BALL_Y0;
          dx_n     = 1'b1;
          dy_n     = 1'b1;
          pad_load = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame_tick <= 1'b0;
      btn_q      <= 1'b0;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      dx         <= 1'b1;
      dy         <= 1'b1;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      serve_cnt  <= 6'd0;
    end else begin
      state      <= state_n;
      frame_tick <= (sx == 10'd0) && (sy == 10'(V_RES));
      btn_q      <= btn_start;
      ball_x     <= ball_x_n;
      ball_y     <= ball_y_n;
      dx         <= dx_n;
      dy         <= dy_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      serve_cnt  <= serve_cnt_n;
    end
  end

  paddle_mover #(.V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)) u_pad_l (
    .clk  (clk_25),
    .rst  (rst),
    .load (pad_load),
    .en   (pad_en),
    .up   (btn_up_l),
    .dn   (btn_dn_l),
    .pad_y(pad_l_y)
  );

  paddle_mover #(.V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)) u_pad_r (
    .clk  (clk_25),
    .rst  (rst),
    .load (pad_load),
    .en   (pad_en),
    .up   (btn_up_r),
    .dn   (btn_dn_r),
    .pad_y(pad_r_y)
  );

endmodule
